// File: rtl/elapsed_up_timer_pkg.sv
// Package: timer_pkg
// Purpose: Shared types and constants for the elapsed up-timer.
//   - state_t: the controller states IDLE / RUN / HOLD / DONE.
//   - DIGIT_W: the digit bus width.
//   - UNITS_MAX_DEF / TENS_MAX_DEF: the default digit terminal values.
//   - is_valid_target(): checks a target against the digit terminal values.
package timer_pkg;

    localparam int unsigned DIGIT_W       = 4;
    localparam int unsigned UNITS_MAX_DEF = 9;
    localparam int unsigned TENS_MAX_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // A target is usable only when both digits are within their terminal values.
    function automatic logic is_valid_target(
        input logic [DIGIT_W-1:0] units,
        input logic [DIGIT_W-1:0] tens,
        input int unsigned        units_max = UNITS_MAX_DEF,
        input int unsigned        tens_max  = TENS_MAX_DEF
    );
        return (32'(units) <= units_max) && (32'(tens) <= tens_max);
    endfunction

endpackage

// File: rtl/elapsed_up_timer_if.sv
// Interface: elapsed_up_timer_if
// Purpose: Command and status bundle between the zone controller and the timer.
// Modports:
//   master - controller side: drives tick/start/pause/stop/target_*, reads status.
//   slave  - timer side: reads commands, drives units/tens/running/done/rollover.
interface elapsed_up_timer_if #(
    parameter int unsigned DIGIT_W = timer_pkg::DIGIT_W
);
    logic               tick;
    logic               start;
    logic               pause;
    logic               stop;
    logic [DIGIT_W-1:0] target_units;
    logic [DIGIT_W-1:0] target_tens;
    logic [DIGIT_W-1:0] units;
    logic [DIGIT_W-1:0] tens;
    logic               running;
    logic               done;
    logic               rollover;

    modport master (
        output tick, start, pause, stop, target_units, target_tens,
        input  units, tens, running, done, rollover
    );

    modport slave (
        input  tick, start, pause, stop, target_units, target_tens,
        output units, tens, running, done, rollover
    );
endinterface

// File: rtl/elapsed_up_timer_digit.sv
// Module: digit_up_counter
// Purpose: One mod-(MAX+1) decimal-style digit for the cascaded up-timer.
// Ports:
//   clock     - system clock (rising edge)
//   reset     - synchronous active-high reset, q -> 0
//   clear     - synchronous clear, q -> 0 (overrides counting)
//   enable    - count enable for this cycle
//   carry_in  - increment request from the lower digit (tie high for units)
//   q         - registered digit value
//   carry_out - combinational: q==MAX && enable && carry_in
module digit_up_counter #(
    parameter int unsigned MAX     = timer_pkg::UNITS_MAX_DEF,
    parameter int unsigned DIGIT_W = timer_pkg::DIGIT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] q,
    output logic               carry_out
);
    logic at_max;

    assign at_max    = (q == DIGIT_W'(MAX));
    assign carry_out = at_max && enable && carry_in;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            q <= '0;
        end else if (enable && carry_in) begin
            q <= at_max ? '0 : q + DIGIT_W'(1);
        end
    end
endmodule

// File: rtl/elapsed_up_timer.sv
// Module: elapsed_up_timer
// Purpose: Two-digit cascaded elapsed-time up counter with start/pause/stop
//   control and a latched completion target. Counts one step per tick.
// Ports:
//   clock - system clock (rising edge)
//   reset - synchronous active-high reset
//   bus   - elapsed_up_timer_if.slave:
//           tick, start, pause, stop, target_units, target_tens (inputs)
//           units, tens, running, done, rollover                (outputs)
// Build option:
//   ELAPSED_UP_TIMER_AUTORELOAD_EN - on target match the count restarts from
//   00 on the same edge and the timer keeps running, giving a periodic done.
module elapsed_up_timer #(
    parameter int unsigned UNITS_MAX = timer_pkg::UNITS_MAX_DEF,
    parameter int unsigned TENS_MAX  = timer_pkg::TENS_MAX_DEF,
    parameter int unsigned DIGIT_W   = timer_pkg::DIGIT_W
) (
    input  logic               clock,
    input  logic               reset,
    elapsed_up_timer_if.slave  bus
);
    import timer_pkg::*;

    state_t             state_q, state_d;
    logic [DIGIT_W-1:0] tgt_units_q, tgt_tens_q;
    logic [DIGIT_W-1:0] units_q, tens_q;
    logic [DIGIT_W-1:0] units_next, tens_next;
    logic               units_co, tens_co;
    logic               idle_like, begin_run, count_en;
    logic               tgt_nonzero, match, clear;
    logic               running_q, done_q, rollover_q;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign begin_run = bus.start && !bus.stop && idle_like;

    // Any command in the same cycle swallows the tick, including an ignored start.
    assign count_en = (state_q == RUN) && bus.tick &&
                      !bus.stop && !bus.start && !bus.pause;

    // Post-increment value, used only when count_en is high.
    assign units_next = units_co ? '0 : units_q + DIGIT_W'(1);
    assign tens_next  = tens_co  ? '0 : (units_co ? tens_q + DIGIT_W'(1) : tens_q);

    assign tgt_nonzero = (tgt_units_q != '0) || (tgt_tens_q != '0);
    assign match       = count_en && tgt_nonzero &&
                         (units_next == tgt_units_q) && (tens_next == tgt_tens_q);

`ifdef ELAPSED_UP_TIMER_AUTORELOAD_EN
    assign clear = bus.stop || begin_run || match;
`else
    assign clear = bus.stop || begin_run;
`endif

    digit_up_counter #(.MAX(UNITS_MAX), .DIGIT_W(DIGIT_W)) u_units (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .enable    (count_en),
        .carry_in  (1'b1),
        .q         (units_q),
        .carry_out (units_co)
    );

    digit_up_counter #(.MAX(TENS_MAX), .DIGIT_W(DIGIT_W)) u_tens (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .enable    (count_en),
        .carry_in  (units_co),
        .q         (tens_q),
        .carry_out (tens_co)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            if (idle_like || state_q == HOLD) begin
                state_d = RUN;
            end
        end else if (bus.pause) begin
            if (state_q == RUN) begin
                state_d = HOLD;
            end
        end else if (match) begin
`ifdef ELAPSED_UP_TIMER_AUTORELOAD_EN
            state_d = RUN;
`else
            state_d = DONE;
`endif
        end
    end

    // Target is captured only when a fresh run begins; invalid targets become free-run.
    always_ff @(posedge clock) begin
        if (reset) begin
            tgt_units_q <= '0;
            tgt_tens_q  <= '0;
        end else if (begin_run) begin
            if (is_valid_target(bus.target_units, bus.target_tens, UNITS_MAX, TENS_MAX)) begin
                tgt_units_q <= bus.target_units;
                tgt_tens_q  <= bus.target_tens;
            end else begin
                tgt_units_q <= '0;
                tgt_tens_q  <= '0;
            end
        end
    end

    // Flags register alongside the count so they line up with the new digits.
    always_ff @(posedge clock) begin
        if (reset) begin
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            running_q  <= (state_d == RUN);
            done_q     <= match;
            rollover_q <= count_en && tens_co;
        end
    end

    assign bus.units    = units_q;
    assign bus.tens     = tens_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.rollover = rollover_q;
endmodule

// File: tb/tb_elapsed_up_timer.sv
// Testbench: tb_elapsed_up_timer
// Drives directed scenarios and random commands; a reference model predicts
// the output after each clock edge and a monitor compares the DUT against it.
module tb_elapsed_up_timer;
    localparam int UM  = 9;
    localparam int TM  = 5;
    localparam int MOD = (UM + 1) * (TM + 1);

    logic clock = 1'b0;
    logic reset;

    elapsed_up_timer_if #(.DIGIT_W(4)) bus ();

    elapsed_up_timer #(.UNITS_MAX(UM), .TENS_MAX(TM), .DIGIT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        int u;
        int t;
        bit run;
        bit dn;
        bit ro;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: elapsed count as a single integer, mode 0=idle 1=run 2=hold 3=done.
    int   m_cnt  = 0;
    int   m_tgt  = 0;
    int   m_mode = 0;
    logic [3:0] tgt_u = '0;
    logic [3:0] tgt_t = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: every edge with a pending prediction is compared 1ns later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("units",    int'(bus.units),    e.u);
                check("tens",     int'(bus.tens),     e.t);
                check("running",  int'(bus.running),  int'(e.run));
                check("done",     int'(bus.done),     int'(e.dn));
                check("rollover", int'(bus.rollover), int'(e.ro));
            end
        end
    end

    task automatic cyc(input bit r, input bit sp, input bit st, input bit pa, input bit tk);
        exp_t e;
        @(negedge clock);
        reset            = r;
        bus.stop         = sp;
        bus.start        = st;
        bus.pause        = pa;
        bus.tick         = tk;
        bus.target_units = tgt_u;
        bus.target_tens  = tgt_t;
        e.dn = 1'b0;
        e.ro = 1'b0;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_tgt = 0;
        end else if (sp) begin
            m_mode = 0; m_cnt = 0;
        end else if (st) begin
            if (m_mode == 0 || m_mode == 3) begin
                m_cnt  = 0;
                m_tgt  = (int'(tgt_u) <= UM && int'(tgt_t) <= TM) ?
                         int'(tgt_t) * (UM + 1) + int'(tgt_u) : 0;
                m_mode = 1;
            end else if (m_mode == 2) begin
                m_mode = 1;
            end
        end else if (pa) begin
            if (m_mode == 1) m_mode = 2;
        end else if (tk && m_mode == 1) begin
            m_cnt = (m_cnt + 1) % MOD;
            if (m_cnt == 0) e.ro = 1'b1;
            if (m_tgt != 0 && m_cnt == m_tgt) begin
                e.dn = 1'b1;
`ifdef ELAPSED_UP_TIMER_AUTORELOAD_EN
                m_cnt = 0;
`else
                m_mode = 3;
`endif
            end
        end
        e.u   = m_cnt % (UM + 1);
        e.t   = m_cnt / (UM + 1);
        e.run = (m_mode == 1);
        sb.push_back(e);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 1);
            for (int j = 1; j < gap; j++) cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic start_with(input int tu, input int tt);
        tgt_u = 4'(tu);
        tgt_t = 4'(tt);
        cyc(0, 0, 1, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.tick = 0; bus.start = 0; bus.pause = 0; bus.stop = 0;
        bus.target_units = '0; bus.target_tens = '0;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-run at 23, then ticks ignored until start.
        start_with(0, 0);
        ticks(23, 1);
        cyc(1, 0, 0, 0, 1);
        ticks(3, 2);

        // Target 02:05 reached after 25 ticks; further ticks hold.
        start_with(5, 2);
        ticks(25, 3);
        ticks(4, 2);

        // Free-run across a full wrap.
        start_with(0, 0);
        ticks(61, 1);

        // Pause coincident with a tick at 00:07, then resume.
        start_with(0, 3);
        ticks(7, 2);
        cyc(0, 0, 0, 1, 1);
        ticks(2, 2);
        cyc(0, 0, 1, 0, 0);
        ticks(2, 2);
        cyc(0, 1, 0, 0, 0);

        // Start and stop together in RUN at 00:04.
        start_with(9, 0);
        ticks(4, 1);
        cyc(0, 1, 1, 0, 1);
        ticks(2, 1);

        // Invalid target tens -> free-run.
        start_with(3, 7);
        ticks(70, 1);

        // Target at the terminal value 05:09.
        start_with(9, 5);
        ticks(62, 1);

        // Short target for periodic behaviour when auto-reload is built in.
        start_with(3, 0);
        ticks(9, 2);
        cyc(0, 1, 0, 0, 0);

        // Random command mix.
        for (int k = 0; k < 3000; k++) begin
            tgt_u = 4'($urandom_range(0, 10));
            tgt_t = 4'($urandom_range(0, 2));
            cyc(($urandom % 300) == 0, ($urandom % 60) == 0, ($urandom % 20) == 0,
                ($urandom % 20) == 0, ($urandom % 2) == 0);
        end

        repeat (3) @(posedge clock);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
